// File: rtl/sram1024x18_port_arbiter.sv
// sram1024x18_port_arbiter: round-robin share of one sram1024x18 port between two requesters, with a power-on clear sweep
module sram1024x18_port_arbiter #(
  parameter int DEPTH = 1024,
  parameter int AW = 10,
  parameter int DW = 18,
  parameter bit INIT_EN = 1'b1,
  parameter logic [DW-1:0] INIT_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wmsk,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wmsk,
  input  logic [DW-1:0] req1_wdata,
  output logic          resp0_valid,
  output logic [DW-1:0] resp0_rdata,
  output logic          resp1_valid,
  output logic [DW-1:0] resp1_rdata,
  output logic          init_done,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wmsk,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] c_q, c_d, addr_q, addr_d, addr_s;
  logic [DW-1:0] wmsk_q, wmsk_d, wdata_q, wdata_d, wmsk_s, wdata_s, rd;
  logic [DW-1:0] resp0_rdata_q, resp0_rdata_d, resp1_rdata_q, resp1_rdata_d;
  logic prio_q, prio_d, init_done_q, init_done_d, cen_q, cen_d, wen_q, wen_d;
  logic t1_v_q, t1_v_d, t1_id_q, t1_id_d, t1_oor_q, t1_oor_d;
  logic t2_v_q, t2_v_d, t2_id_q, t2_id_d, t2_oor_q, t2_oor_d;
  logic resp0_valid_q, resp0_valid_d, resp1_valid_q, resp1_valid_d;
  logic g0, g1, acc0, acc1, acc, we_s, oor;
  // prio_q=0 means requester 0 wins a tie
  assign g0 = req0_valid && (!req1_valid || !prio_q);
  assign g1 = req1_valid && (!req0_valid || prio_q);
  assign req0_ready = state_q == RUN && g0;
  assign req1_ready = state_q == RUN && g1;
  assign acc0 = req0_valid && req0_ready;
  assign acc1 = req1_valid && req1_ready;
  assign acc = acc0 || acc1;
  assign we_s = acc1 ? req1_we : req0_we;
  assign addr_s = acc1 ? req1_addr : req0_addr;
  assign wmsk_s = acc1 ? req1_wmsk : req0_wmsk;
  assign wdata_s = acc1 ? req1_wdata : req0_wdata;
  assign oor = 32'(addr_s) >= DEPTH;
  // out-of-range reads skip the sram and return zero at the normal latency
  assign rd = t2_oor_q ? '0 : sram_rdata;
  always_comb begin
    state_d = state_q;
    c_d = c_q;
    prio_d = acc ? acc0 : prio_q;
    init_done_d = state_q == RUN;
    cen_d = 1'b1;
    wen_d = 1'b1;
    addr_d = addr_q;
    wmsk_d = wmsk_q;
    wdata_d = wdata_q;
    if (state_q == CLEAR) begin
      cen_d = 1'b0;
      wen_d = 1'b0;
      addr_d = c_q;
      wmsk_d = '0;
      wdata_d = INIT_VALUE;
      c_d = c_q + 1'b1;
      state_d = c_q == AW'(DEPTH - 1) ? RUN : CLEAR;
    end else if (acc) begin
      cen_d = oor;
      wen_d = ~we_s;
      addr_d = addr_s;
      wmsk_d = wmsk_s;
      wdata_d = wdata_s;
    end
    t1_v_d = acc && !we_s;
    t1_id_d = acc1;
    t1_oor_d = oor;
    t2_v_d = t1_v_q;
    t2_id_d = t1_id_q;
    t2_oor_d = t1_oor_q;
    resp0_valid_d = t2_v_q && !t2_id_q;
    resp1_valid_d = t2_v_q && t2_id_q;
    resp0_rdata_d = resp0_valid_d ? rd : resp0_rdata_q;
    resp1_rdata_d = resp1_valid_d ? rd : resp1_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT_EN ? CLEAR : RUN;
      c_q <= '0;
      prio_q <= 1'b0;
      init_done_q <= 1'b0;
      cen_q <= 1'b1;
      wen_q <= 1'b1;
      addr_q <= '0;
      wmsk_q <= '1;
      wdata_q <= '0;
      t1_v_q <= 1'b0;
      t1_id_q <= 1'b0;
      t1_oor_q <= 1'b0;
      t2_v_q <= 1'b0;
      t2_id_q <= 1'b0;
      t2_oor_q <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_rdata_q <= '0;
      resp1_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      prio_q <= prio_d;
      init_done_q <= init_done_d;
      cen_q <= cen_d;
      wen_q <= wen_d;
      addr_q <= addr_d;
      wmsk_q <= wmsk_d;
      wdata_q <= wdata_d;
      t1_v_q <= t1_v_d;
      t1_id_q <= t1_id_d;
      t1_oor_q <= t1_oor_d;
      t2_v_q <= t2_v_d;
      t2_id_q <= t2_id_d;
      t2_oor_q <= t2_oor_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_rdata_q <= resp0_rdata_d;
      resp1_rdata_q <= resp1_rdata_d;
    end
  end
  assign init_done = init_done_q;
  assign sram_cen = cen_q;
  assign sram_wen = wen_q;
  assign sram_addr = addr_q;
  assign sram_wmsk = wmsk_q;
  assign sram_wdata = wdata_q;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_rdata = resp0_rdata_q;
  assign resp1_rdata = resp1_rdata_q;
endmodule
